// File: rtl/pair_step_monitor_if.sv
// Bus between the pair_step_monitor and the harness that owns the counter.
// Handshake: start is a request that is accepted only on a rising edge where
// busy=0 (ready == !busy); once accepted, busy stays high until the cycle
// after the single-cycle done pulse, and any start seen while busy is dropped.
// run_len is qualified by start. x_in/y_in are the counter outputs and are
// always valid; selector is the registered drive back to the counter.
interface pair_step_monitor_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic [15:0]      run_len;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic             selector;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [15:0]      first_err_cycle;
  logic             violation;

  // Harness / counter side.
  modport master (
    output start, run_len, x_in, y_in,
    input  selector, busy, done, pass, err_count, first_err_cycle, violation
  );

  // Monitor side.
  modport slave (
    input  start, run_len, x_in, y_in,
    output selector, busy, done, pass, err_count, first_err_cycle, violation
  );
endinterface

// File: rtl/pair_step_monitor.sv
// Stimulus and checker partner for the paired x/y step counter.
// Drives the counter's selector from an 8-bit Fibonacci LFSR for a programmed
// number of cycles, keeps a shadow x/y model that steps on the same edges as
// the counter, compares every RUN/DRAIN cycle, flags the forbidden state and
// reports pass/fail once per run.
module pair_step_monitor #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STEP      = 10,
  parameter int unsigned X_INIT    = 5,
  parameter int unsigned Y_INIT    = 0,
  parameter int unsigned FORBID_X  = 20,
  parameter int unsigned FORBID_Y  = 0,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int unsigned ERR_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  pair_step_monitor_if.slave  bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] STEP_V     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] X_INIT_V   = WIDTH'(X_INIT);
  localparam logic [WIDTH-1:0] Y_INIT_V   = WIDTH'(Y_INIT);
  localparam logic [WIDTH-1:0] FORBID_X_V = WIDTH'(FORBID_X);
  localparam logic [WIDTH-1:0] FORBID_Y_V = WIDTH'(FORBID_Y);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;
  localparam logic [15:0]      NO_ERR     = 16'hFFFF;

  // Fibonacci LFSR, taps 8,6,5,4; the new bit enters at bit 0, which is the
  // bit used as the selector value.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  state_t           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             selector_q, selector_d;
  logic [WIDTH-1:0] shadow_x_q, shadow_y_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic [15:0]      first_err_q, first_err_d;
  logic             violation_q, violation_d;
  logic             pass_q, pass_d;

  logic             cmp_active;
  logic             mismatch;
  logic             forbidden;

  // Control state, run length, cycle index, LFSR and selector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      selector_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      selector_q <= selector_d;
    end
  end

  // Next-state logic. The selector for a RUN cycle is loaded on the edge that
  // enters that cycle, so the LFSR advances exactly once per RUN cycle and the
  // selector is already low when DRAIN begins.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    selector_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d = bus.run_len;
          cnt_d = '0;
          if (bus.run_len == 16'd0) begin
            state_d = S_DRAIN;
          end else begin
            state_d    = S_RUN;
            selector_d = lfsr_q[0];
            lfsr_d     = lfsr_step(lfsr_q);
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == len_q - 16'd1) begin
          state_d = S_DRAIN;
        end else begin
          selector_d = lfsr_q[0];
          lfsr_d     = lfsr_step(lfsr_q);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shadow model: steps on exactly the edges where the counter steps.
  // It is only cleared by rst, so it tracks the counter across runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_x_q <= X_INIT_V;
      shadow_y_q <= Y_INIT_V;
    end else if (selector_q) begin
      shadow_x_q <= shadow_x_q + STEP_V;
      shadow_y_q <= shadow_y_q + STEP_V;
    end
  end

  // Compare against the shadow, track the forbidden state and form the verdict.
  always_comb begin
    cmp_active  = (state_q == S_RUN) || (state_q == S_DRAIN);
    mismatch    = cmp_active &&
                  ((bus.x_in != shadow_x_q) || (bus.y_in != shadow_y_q));
    forbidden   = cmp_active &&
                  (bus.x_in == FORBID_X_V) && (bus.y_in == FORBID_Y_V);
    err_d       = err_q;
    first_err_d = first_err_q;
    violation_d = violation_q;
    pass_d      = pass_q;
    if ((state_q == S_IDLE) && bus.start) begin
      err_d       = '0;
      first_err_d = NO_ERR;
      violation_d = 1'b0;
      pass_d      = 1'b0;
    end else begin
      if (mismatch) begin
        if (err_q != ERR_MAX) begin
          err_d = err_q + 1'b1;
        end
        if (first_err_q == NO_ERR) begin
          first_err_d = cnt_q;
        end
      end
      if (forbidden) begin
        violation_d = 1'b1;
      end
      // The DRAIN compare lands on the same edge that enters DONE, so the
      // verdict uses the post-update counts.
      if (state_q == S_DRAIN) begin
        pass_d = (err_d == '0) && !violation_d;
      end
    end
  end

  // Result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q       <= '0;
      first_err_q <= NO_ERR;
      violation_q <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      err_q       <= err_d;
      first_err_q <= first_err_d;
      violation_q <= violation_d;
      pass_q      <= pass_d;
    end
  end

  assign bus.selector        = selector_q;
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.done            = (state_q == S_DONE);
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_err_cycle = first_err_q;
  assign bus.violation       = violation_q;
  assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_pair_step_monitor.sv
// Directed bench for pair_step_monitor: a behavioural step counter (with a
// y-stuck stub and an x/y override) sits beside the monitor.
module tb_pair_step_monitor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pair_step_monitor_if #(.WIDTH(8), .ERR_W(8)) bus ();
  logic [1:0] dbg_state;

  pair_step_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Behavioural counter: x:=5, y:=0 on reset, both +10 when selector=1.
  logic [7:0] gx, gy;
  logic       stub_y0;
  logic       force_en;
  logic [7:0] force_x, force_y;

  always @(posedge clk) begin
    if (rst) begin
      gx <= 8'd5;
      gy <= 8'd0;
    end else if (bus.selector) begin
      gx <= gx + 8'd10;
      gy <= gy + 8'd10;
    end
  end

  assign bus.x_in = force_en ? force_x : gx;
  assign bus.y_in = force_en ? force_y : (stub_y0 ? 8'd0 : gy);

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] tb_lfsr;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tb_lfsr = 8'hA5;
  endtask

  // Starts a run and follows it to done. Cycle 1 is the cycle right after the
  // edge that samples start. Checks selector against the bench LFSR each cycle.
  task automatic run_wait(input logic [15:0] len, input int force_at, input int poke_at,
                          output int done_cyc, output int sel_errs, output int ones,
                          output logic [3:0] first4, output logic viol_seen);
    int cyc;
    logic exp_sel;
    done_cyc = -1; sel_errs = 0; ones = 0; first4 = 4'b0000; viol_seen = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.run_len = len;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (cyc <= int'(len) + 60) begin
      if (cyc == force_at) begin
        force_en = 1'b1; force_x = 8'd20; force_y = 8'd0;
      end
      if (force_at > 0 && cyc == force_at + 1) begin
        force_en  = 1'b0;
        viol_seen = bus.violation;
      end
      if (cyc == poke_at) begin
        bus.start = 1'b1; bus.run_len = 16'd3;
      end
      if (poke_at > 0 && cyc == poke_at + 1) bus.start = 1'b0;
      if (cyc <= int'(len)) begin
        exp_sel = tb_lfsr[0];
        tb_lfsr = lfsr_next(tb_lfsr);
        if (bus.selector !== exp_sel) sel_errs++;
        if (bus.selector === 1'b1) ones++;
        if (cyc <= 4) first4[cyc-1] = bus.selector;
      end else if (bus.selector !== 1'b0) begin
        sel_errs++;
      end
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.selector !== 1'b0) begin n_fail++; $display("FAIL reset_selector: got %0b want 0", bus.selector); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", bus.done); end
    n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %0b want 0", bus.pass); end
    n_checks++; if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", bus.err_count); end
    n_checks++; if (bus.first_err_cycle !== 16'hFFFF) begin n_fail++; $display("FAIL reset_first_err: got %h want ffff", bus.first_err_cycle); end
    n_checks++; if (bus.violation !== 1'b0) begin n_fail++; $display("FAIL reset_violation: got %0b want 0", bus.violation); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_golden();
    int dc, se, ones; logic [3:0] f4; logic vs;
    do_reset();
    run_wait(16'd300, 0, 0, dc, se, ones, f4, vs);
    n_checks++; if (dc != 302) begin n_fail++; $display("FAIL golden_latency: got %0d want 302", dc); end
    n_checks++; if (se != 0) begin n_fail++; $display("FAIL golden_selector_seq: got %0d bad cycles want 0", se); end
    n_checks++; if (f4 !== 4'b0101) begin n_fail++; $display("FAIL golden_first_selectors: got %b want 0101", f4); end
    n_checks++; if (ones * 10 + 5 <= 255) begin n_fail++; $display("FAIL golden_x_wraps: got %0d steps want >=26", ones); end
    n_checks++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL golden_pass: got %0b want 1", bus.pass); end
    n_checks++; if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL golden_err: got %0d want 0", bus.err_count); end
    n_checks++; if (bus.first_err_cycle !== 16'hFFFF) begin n_fail++; $display("FAIL golden_first_err: got %h want ffff", bus.first_err_cycle); end
    n_checks++; if (bus.violation !== 1'b0) begin n_fail++; $display("FAIL golden_violation: got %0b want 0", bus.violation); end
  endtask

  task automatic test_stuck_y();
    int dc, se, ones; logic [3:0] f4; logic vs;
    do_reset();
    stub_y0 = 1'b1;
    run_wait(16'd50, 0, 0, dc, se, ones, f4, vs);
    stub_y0 = 1'b0;
    n_checks++; if (dc != 52) begin n_fail++; $display("FAIL stuck_latency: got %0d want 52", dc); end
    // Cycle 0 drives selector=1, so the first divergence is seen at index 1.
    n_checks++; if (bus.first_err_cycle !== 16'd1) begin n_fail++; $display("FAIL stuck_first_err: got %0d want 1", bus.first_err_cycle); end
    n_checks++; if (bus.err_count == 8'd0 || bus.err_count > 8'd51) begin n_fail++; $display("FAIL stuck_err: got %0d want 1..51", bus.err_count); end
    n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL stuck_pass: got %0b want 0", bus.pass); end
    // Counter internally kept pace, so a clean run clears the verdict and passes.
    run_wait(16'd20, 0, 0, dc, se, ones, f4, vs);
    n_checks++; if (bus.pass !== 1'b1 || bus.err_count !== 8'd0) begin n_fail++; $display("FAIL rerun_clean: got pass=%0b err=%0d want pass=1 err=0", bus.pass, bus.err_count); end
    n_checks++; if (bus.first_err_cycle !== 16'hFFFF) begin n_fail++; $display("FAIL rerun_first_err: got %h want ffff", bus.first_err_cycle); end
  endtask

  task automatic test_saturation();
    int dc, se, ones; logic [3:0] f4; logic vs;
    do_reset();
    stub_y0 = 1'b1;
    run_wait(16'd300, 0, 0, dc, se, ones, f4, vs);
    stub_y0 = 1'b0;
    n_checks++; if (bus.err_count !== 8'd255) begin n_fail++; $display("FAIL sat_err: got %0d want 255", bus.err_count); end
    n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL sat_pass: got %0b want 0", bus.pass); end
  endtask

  task automatic test_forbidden();
    int dc, se, ones; logic [3:0] f4; logic vs;
    do_reset();
    // Forbidden values while IDLE must not be flagged.
    @(negedge clk);
    force_en = 1'b1; force_x = 8'd20; force_y = 8'd0;
    @(posedge clk); #1;
    force_en = 1'b0;
    n_checks++; if (bus.violation !== 1'b0) begin n_fail++; $display("FAIL forbid_idle: got %0b want 0", bus.violation); end
    run_wait(16'd30, 8, 0, dc, se, ones, f4, vs);
    n_checks++; if (vs !== 1'b1) begin n_fail++; $display("FAIL forbid_set: got %0b want 1", vs); end
    n_checks++; if (dc != 32) begin n_fail++; $display("FAIL forbid_latency: got %0d want 32", dc); end
    n_checks++; if (bus.violation !== 1'b1) begin n_fail++; $display("FAIL forbid_sticky: got %0b want 1", bus.violation); end
    n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL forbid_pass: got %0b want 0", bus.pass); end
  endtask

  task automatic test_zero_len();
    int dc, se, ones; logic [3:0] f4; logic vs;
    do_reset();
    run_wait(16'd0, 0, 0, dc, se, ones, f4, vs);
    n_checks++; if (dc != 2) begin n_fail++; $display("FAIL zero_latency: got %0d want 2", dc); end
    n_checks++; if (se != 0) begin n_fail++; $display("FAIL zero_selector: got %0d high cycles want 0", se); end
    n_checks++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL zero_pass: got %0b want 1", bus.pass); end
    // Second start: pass must drop in the cycle after start, then return.
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.run_len = 16'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++; if (bus.pass !== 1'b0 || bus.selector !== 1'b0) begin n_fail++; $display("FAIL zero2_clear: got pass=%0b sel=%0b want 0 0", bus.pass, bus.selector); end
    @(posedge clk); #1;
    n_checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b1) begin n_fail++; $display("FAIL zero2_done: got done=%0b pass=%0b want 1 1", bus.done, bus.pass); end
  endtask

  task automatic test_back_to_back();
    int dc, se, ones; logic [3:0] f4; logic vs;
    do_reset();
    run_wait(16'd20, 0, 5, dc, se, ones, f4, vs);
    n_checks++; if (dc != 22) begin n_fail++; $display("FAIL busy_start_ignored: got done at %0d want 22", dc); end
    n_checks++; if (se != 0) begin n_fail++; $display("FAIL busy_selector_seq: got %0d bad cycles want 0", se); end
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %0b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_run();
    bit seen_done;
    do_reset();
    @(negedge clk);
    bus.start = 1'b1; bus.run_len = 16'd100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.selector !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got busy=%0b sel=%0b want 0 0", bus.busy, bus.selector); end
    n_checks++; if (bus.pass !== 1'b0 || bus.first_err_cycle !== 16'hFFFF) begin n_fail++; $display("FAIL midrst_values: got pass=%0b first=%h want 0 ffff", bus.pass, bus.first_err_cycle); end
    @(negedge clk);
    rst = 1'b0;
    tb_lfsr = 8'hA5;
    seen_done = 1'b0;
    repeat (110) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
    end
    n_checks++; if (seen_done) begin n_fail++; $display("FAIL midrst_no_done: got activity after reset want none"); end
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.run_len = 16'd0;
    stub_y0 = 1'b0; force_en = 1'b0; force_x = 8'd0; force_y = 8'd0;
    tb_lfsr = 8'hA5;
    test_reset();
    test_golden();
    test_stuck_y();
    test_saturation();
    test_forbidden();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
